multi_queue_bank: RTL

//  Bank of NB_QUEUES independent FIFO queues with one shared push port and per-queue pop.

---
 rtl/multi_queue_bank.sv | 124 ++++++++++++
 1 files changed

// File: rtl/multi_queue_bank.sv
// multi_queue_bank: NB_QUEUES independent FIFO queues behind one shared push
// port, each with its own pop strobe and a first-word-fall-through head.
// Every queue tracks its occupancy, flags overflow/underflow stickily and
// drives a kill_the_core throttle with high/low-threshold hysteresis.
module multi_queue_bank #(
    parameter int DATA_SIZE     = 8,
    parameter int QUEUE_LENGTH  = 4,
    parameter int NB_QUEUES     = 4,
    parameter int REGISTER_SIZE = 32,
    localparam int QW = (NB_QUEUES > 1) ? $clog2(NB_QUEUES) : 1,
    localparam int PW = (QUEUE_LENGTH > 1) ? $clog2(QUEUE_LENGTH) : 1,
    localparam int CW = $clog2(QUEUE_LENGTH + 1)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NB_QUEUES*REGISTER_SIZE-1:0] higher_threshold,
    input  logic [NB_QUEUES*REGISTER_SIZE-1:0] lower_threshold,
    input  logic [DATA_SIZE-1:0]               valueIn,
    input  logic                               valueInValid,
    input  logic [QW-1:0]                      valueInId,
    input  logic [NB_QUEUES-1:0]               consumed,
    output logic [NB_QUEUES*DATA_SIZE-1:0]     valueOut,
    output logic [NB_QUEUES-1:0]               empty,
    output logic [NB_QUEUES-1:0]               full,
    output logic [NB_QUEUES*CW-1:0]            occupancy,
    output logic [NB_QUEUES-1:0]               kill_the_core,
    output logic [NB_QUEUES-1:0]               overflow,
    output logic [NB_QUEUES-1:0]               underflow
);

    generate
        for (genvar gi = 0; gi < NB_QUEUES; gi++) begin : g_queue
            logic [DATA_SIZE-1:0]     mem [QUEUE_LENGTH];
            logic [PW-1:0]            head_reg;
            logic [PW-1:0]            tail_reg;
            logic [PW-1:0]            head_next;
            logic [PW-1:0]            tail_next;
            logic [CW-1:0]            occ_reg;
            logic [CW-1:0]            occ_next;
            logic                     empty_reg;
            logic                     full_reg;
            logic                     kill_reg;
            logic                     overflow_reg;
            logic                     underflow_reg;
            logic                     push_req;
            logic                     push_ok;
            logic                     pop_ok;
            logic [REGISTER_SIZE-1:0] high_lvl;
            logic [REGISTER_SIZE-1:0] low_lvl;
            logic [REGISTER_SIZE-1:0] occ_ext;

            // Ids at or above NB_QUEUES match no queue, so such pushes vanish.
            assign push_req = valueInValid && (valueInId == QW'(gi));
            assign pop_ok   = consumed[gi] && !empty_reg;
            // A full queue still accepts a push when the same cycle frees a slot.
            assign push_ok  = push_req && (!full_reg || pop_ok);

            assign high_lvl = higher_threshold[gi*REGISTER_SIZE +: REGISTER_SIZE];
            assign low_lvl  = lower_threshold[gi*REGISTER_SIZE +: REGISTER_SIZE];
            assign occ_ext  = REGISTER_SIZE'(occ_reg);

            // Pointer wrap and next occupancy; explicit wrap keeps odd lengths correct.
            always_comb begin
                head_next = (head_reg == PW'(QUEUE_LENGTH - 1)) ? '0 : head_reg + PW'(1);
                tail_next = (tail_reg == PW'(QUEUE_LENGTH - 1)) ? '0 : tail_reg + PW'(1);
                occ_next  = occ_reg + CW'(push_ok) - CW'(pop_ok);
            end

            // Entry storage: written on an accepted push, never cleared.
            always_ff @(posedge clock) begin
                if (push_ok) begin
                    mem[tail_reg] <= valueIn;
                end
            end

            // Pointers, status, sticky error flags and the throttle hysteresis.
            always_ff @(posedge clock) begin
                if (!reset) begin
                    head_reg      <= '0;
                    tail_reg      <= '0;
                    occ_reg       <= '0;
                    empty_reg     <= 1'b1;
                    full_reg      <= 1'b0;
                    kill_reg      <= 1'b0;
                    overflow_reg  <= 1'b0;
                    underflow_reg <= 1'b0;
                end else begin
                    if (push_ok) begin
                        tail_reg <= tail_next;
                    end
                    if (pop_ok) begin
                        head_reg <= head_next;
                    end
                    occ_reg   <= occ_next;
                    empty_reg <= (occ_next == '0);
                    full_reg  <= (occ_next == CW'(QUEUE_LENGTH));
                    if (push_req && !push_ok) begin
                        overflow_reg <= 1'b1;
                    end
                    if (consumed[gi] && empty_reg) begin
                        underflow_reg <= 1'b1;
                    end
                    // Throttle looks at the occupancy held before this edge.
                    if (high_lvl == '0) begin
                        kill_reg <= 1'b0;
                    end else if (!kill_reg && (occ_ext >= high_lvl)) begin
                        kill_reg <= 1'b1;
                    end else if (kill_reg && (occ_ext <= low_lvl)) begin
                        kill_reg <= 1'b0;
                    end
                end
            end

            assign valueOut[gi*DATA_SIZE +: DATA_SIZE] = mem[head_reg];
            assign occupancy[gi*CW +: CW]              = occ_reg;
            assign empty[gi]                           = empty_reg;
            assign full[gi]                            = full_reg;
            assign kill_the_core[gi]                   = kill_reg;
            assign overflow[gi]                        = overflow_reg;
            assign underflow[gi]                       = underflow_reg;
        end
    endgenerate

endmodule
